// File: rtl/present_cipher_core.sv
// Iterative PRESENT block cipher, one round per clock, 80/128-bit key,
// runtime encrypt/decrypt, valid/ready handshake on input and output.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  input handshake; mode, data_in, key sampled on accept
//   mode                 0 = encrypt, 1 = decrypt
//   data_in  [63:0]      plaintext or ciphertext
//   key      [KW-1:0]    cipher key
//   out_valid/out_ready  output handshake; data_out held until consumed
//   data_out [63:0]      result
//   busy                 high whenever the FSM is not idle
module present_cipher_core #(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          data_out,
  output logic                 busy
);

  localparam int KW = KEY_WIDTH;
  // Bit position where the round counter is folded into the key
  localparam int RC_LO = (KW == 128) ? 62 : 15;
  localparam logic [4:0] RC_LAST = 5'(ROUNDS);
  // S-box tables, nibble 0 in the least significant position
  localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SINV = 64'hA970_364B_D21C_8FE5;

  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_kw
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_WHITEN,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] isb(input logic [3:0] x);
    return SINV[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sub_l(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = sb(s[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] isub_l(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = isb(s[4*n +: 4]);
    return o;
  endfunction

  // Bit i lands at 16*(i%4) + i/4, i.e. the 6-bit index with its
  // two low bits swapped to the top.
  function automatic logic [63:0] perm_l(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  p;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      p = 6'(i);
      o[{p[1:0], p[5:2]}] = s[i];
    end
    return o;
  endfunction

  function automatic logic [63:0] iperm_l(input logic [63:0] s);
    logic [63:0] o;
    logic [5:0]  p;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      p = 6'(i);
      o[i] = s[{p[1:0], p[5:2]}];
    end
    return o;
  endfunction

  function automatic logic [KW-1:0] key_fwd(
    input logic [KW-1:0] k,
    input logic [4:0]    rc
  );
    logic [KW-1:0] t;
    t = {k[KW-62:0], k[KW-1:KW-61]};
    t[KW-1 -: 4] = sb(t[KW-1 -: 4]);
    if (KW == 128) t[KW-5 -: 4] = sb(t[KW-5 -: 4]);
    t[RC_LO +: 5] = t[RC_LO +: 5] ^ rc;
    return t;
  endfunction

  function automatic logic [KW-1:0] key_inv(
    input logic [KW-1:0] k,
    input logic [4:0]    rc
  );
    logic [KW-1:0] t;
    t = k;
    t[RC_LO +: 5] = t[RC_LO +: 5] ^ rc;
    t[KW-1 -: 4] = isb(t[KW-1 -: 4]);
    if (KW == 128) t[KW-5 -: 4] = isb(t[KW-5 -: 4]);
    return {t[60:0], t[KW-1:61]};
  endfunction

  state_e        st_q;
  logic [63:0]   data_q;
  logic [KW-1:0] key_q;
  logic [4:0]    rc_q;
  logic          dec_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [63:0]   dout_q;

  logic [KW-1:0] kf_d;
  logic [KW-1:0] ki_d;
  logic [63:0]   ktop;
  logic [63:0]   enc_d;
  logic [63:0]   dec_d;

  assign kf_d  = key_fwd(key_q, rc_q);
  assign ki_d  = key_inv(key_q, rc_q);
  assign ktop  = key_q[KW-1 -: 64];
  assign enc_d = perm_l(sub_l(data_q ^ ktop));
  assign dec_d = isub_l(iperm_l(data_q)) ^ ki_d[KW-1 -: 64];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_IDLE;
      data_q      <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= data_in;
            key_q      <= key;
            rc_q       <= 5'd1;
            dec_q      <= mode;
            in_ready_q <= 1'b0;
            st_q       <= mode ? S_KEYEXP : S_ROUND;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_KEYEXP: begin
          key_q <= kf_d;
          if (rc_q == RC_LAST) st_q <= S_WHITEN;
          else rc_q <= rc_q + 5'd1;
        end
        S_WHITEN: begin
          data_q <= data_q ^ ktop;
          rc_q   <= RC_LAST;
          st_q   <= S_ROUND;
        end
        S_ROUND: begin
          if (!dec_q) begin
            data_q <= enc_d;
            key_q  <= kf_d;
            if (rc_q == RC_LAST) st_q <= S_FINAL;
            else rc_q <= rc_q + 5'd1;
          end else begin
            data_q <= dec_d;
            key_q  <= ki_d;
            if (rc_q == 5'd1) st_q <= S_FINAL;
            else rc_q <= rc_q - 5'd1;
          end
        end
        S_FINAL: begin
          dout_q      <= dec_q ? data_q : (data_q ^ ktop);
          out_valid_q <= 1'b1;
          st_q        <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            st_q        <= S_IDLE;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = dout_q;
  assign busy      = (st_q != S_IDLE);

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: known vectors, handshake corner cases,
// and random traffic against an algorithmic PRESENT model.
module tb_present_cipher_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic [63:0] din = '0;
  logic ordy = 1'b0;
  logic iv80 = 1'b0, iv128 = 1'b0;
  logic [79:0] key80 = '0;
  logic [127:0] key128 = '0;
  logic ir80, ov80, b80;
  logic ir128, ov128, b128;
  logic [63:0] do80, do128;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  present_cipher_core #(.KEY_WIDTH(80)) u80 (
    .clk(clk), .rst(rst),
    .in_valid(iv80), .in_ready(ir80),
    .mode(mode), .data_in(din), .key(key80),
    .out_valid(ov80), .out_ready(ordy),
    .data_out(do80), .busy(b80)
  );

  present_cipher_core #(.KEY_WIDTH(128)) u128 (
    .clk(clk), .rst(rst),
    .in_valid(iv128), .in_ready(ir128),
    .mode(mode), .data_in(din), .key(key128),
    .out_valid(ov128), .out_ready(ordy),
    .data_out(do128), .busy(b128)
  );

  int SB[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic int inv_sb(int v);
    for (int j = 0; j < 16; j++) if (SB[j] == v) return j;
    return 0;
  endfunction

  function automatic logic [63:0] m_sub(logic [63:0] s, bit inv);
    logic [63:0] o;
    int v;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      v = int'(s[4*n +: 4]);
      o[4*n +: 4] = 4'(inv ? inv_sb(v) : SB[v]);
    end
    return o;
  endfunction

  function automatic logic [63:0] m_perm(logic [63:0] s, bit inv);
    logic [63:0] o;
    int dst;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      dst = (i == 63) ? 63 : (16 * i) % 63;
      if (inv) o[i] = s[dst];
      else o[dst] = s[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] m_next(bit w, logic [127:0] k, int r);
    logic [79:0]  a;
    logic [127:0] b;
    if (w) begin
      b = (k << 61) | (k >> 67);
      b[127:124] = 4'(SB[b[127:124]]);
      b[123:120] = 4'(SB[b[123:120]]);
      b[66:62] = b[66:62] ^ 5'(r);
      return b;
    end
    a = k[79:0];
    a = (a << 61) | (a >> 19);
    a[79:76] = 4'(SB[a[79:76]]);
    a[19:15] = a[19:15] ^ 5'(r);
    return {48'h0, a};
  endfunction

  function automatic logic [63:0] m_top(bit w, logic [127:0] k);
    return w ? k[127:64] : k[79:16];
  endfunction

  function automatic logic [63:0] ref_run(bit w, bit dec, logic [63:0] d, logic [127:0] k);
    logic [63:0]  rk[33];
    logic [127:0] kk;
    logic [63:0]  s;
    kk = k;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = m_top(w, kk);
      kk = m_next(w, kk, r);
    end
    rk[0] = '0;
    if (!dec) begin
      s = d;
      for (int r = 1; r <= 31; r++) s = m_perm(m_sub(s ^ rk[r], 0), 0);
      return s ^ rk[32];
    end
    s = d ^ rk[32];
    for (int r = 31; r >= 1; r--) s = m_sub(m_perm(s, 1), 1) ^ rk[r];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic g_ir(bit w);
    return w ? ir128 : ir80;
  endfunction

  function automatic logic g_ov(bit w);
    return w ? ov128 : ov80;
  endfunction

  function automatic logic [63:0] g_do(bit w);
    return w ? do128 : do80;
  endfunction

  task automatic wait_ready(input bit w);
    int n;
    n = 0;
    @(negedge clk);
    while (!g_ir(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 0, 1);
  endtask

  task automatic accept(input bit w, input bit m, input logic [63:0] d, input logic [127:0] k);
    mode = m;
    din = d;
    key80 = k[79:0];
    key128 = k;
    if (w) iv128 = 1'b1;
    else iv80 = 1'b1;
    @(posedge clk);
    #1;
    iv80 = 1'b0;
    iv128 = 1'b0;
    mode = ~m;
    din = {$urandom, $urandom};
    key80 = {$urandom, $urandom, $urandom};
    key128 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input bit w, output int lat);
    lat = 0;
    while (!g_ov(w) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input bit w, input bit m, input logic [63:0] d,
                       input logic [127:0] k, input int hold, input bit early,
                       output logic [63:0] res, output int lat);
    wait_ready(w);
    accept(w, m, d, k);
    if (early) ordy = 1'b1;
    wait_out(w, lat);
    res = g_do(w);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      ordy = 1'b1;
    end
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("ov_drop", g_ov(w), 0);
  endtask

  typedef struct {
    bit w;
    bit m;
    logic [63:0] d;
    logic [127:0] k;
    logic [63:0] exp;
    int lat;
  } vec_t;

  vec_t tbl[10];

  localparam logic [127:0] KF80 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ALLF = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] res, exp, d;
    logic [127:0] k;
    int lat;
    bit w, m;

    tbl[0] = '{0, 0, 64'h0, 128'h0, 64'h5579C1387B228445, 32};
    tbl[1] = '{0, 0, 64'h0, KF80, 64'hE72C46C0F5945049, 32};
    tbl[2] = '{0, 0, ALLF, 128'h0, 64'hA112FFC72F68417B, 32};
    tbl[3] = '{0, 0, ALLF, KF80, 64'h3333DCD3213210D2, 32};
    tbl[4] = '{0, 1, 64'h3333DCD3213210D2, KF80, ALLF, 64};
    tbl[5] = '{0, 1, 64'h5579C1387B228445, 128'h0, 64'h0, 64};
    tbl[6] = '{0, 1, 64'hE72C46C0F5945049, KF80, 64'h0, 64};
    tbl[7] = '{0, 1, 64'hA112FFC72F68417B, 128'h0, ALLF, 64};
    tbl[8] = '{1, 0, 64'h0, 128'h0, 64'h96DB702A2E6900AF, 32};
    tbl[9] = '{1, 1, 64'h96DB702A2E6900AF, 128'h0, 64'h0, 64};

    // reset state
    @(posedge clk);
    #1;
    chk("rst_in_ready", ir80, 0);
    chk("rst_out_valid", ov80, 0);
    chk("rst_data_out", do80, 0);
    chk("rst_busy", b80, 0);
    chk("rst_busy128", b128, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready80", ir80, 1);
    chk("post_rst_ready128", ir128, 1);

    // known-answer vectors
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].w, tbl[i].m, tbl[i].d, tbl[i].k,
            int'($urandom_range(0, 3)), 1'b0, res, lat);
      chk($sformatf("kat%0d_data", i), res, tbl[i].exp);
      chk($sformatf("kat%0d_lat", i), lat, tbl[i].lat);
    end

    // out_ready already high: exactly one cycle of out_valid
    wait_ready(0);
    accept(0, 0, ALLF, 128'h0);
    ordy = 1'b1;
    wait_out(0, lat);
    chk("early_lat", lat, 32);
    chk("early_data", do80, 64'hA112FFC72F68417B);
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("early_ov_one_cycle", ov80, 0);
    chk("early_in_ready_low", ir80, 0);
    @(posedge clk);
    #1;
    chk("early_in_ready_high", ir80, 1);

    // backpressure: result held, new inputs ignored
    wait_ready(0);
    accept(0, 0, 64'h0, KF80);
    wait_out(0, lat);
    chk("bp_lat", lat, 32);
    for (int c = 0; c < 10; c++) begin
      iv80 = c[0];
      din = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk("bp_data_hold", do80, 64'hE72C46C0F5945049);
      chk("bp_in_ready", ir80, 0);
      chk("bp_out_valid", ov80, 1);
    end
    iv80 = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("bp_ov_drop", ov80, 0);
    chk("bp_ready_still_low", ir80, 0);
    @(posedge clk);
    #1;
    chk("bp_ready_rise", ir80, 1);
    chk("bp_busy_idle", b80, 0);

    // reset in the middle of an encryption
    wait_ready(0);
    accept(0, 0, ALLF, KF80);
    repeat (13) @(posedge clk);
    #1;
    chk("mid_busy", b80, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_ov", ov80, 0);
    chk("mid_rst_data", do80, 0);
    chk("mid_rst_busy", b80, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_ready", ir80, 1);
    do_op(0, 0, 64'h0, 128'h0, 0, 1'b0, res, lat);
    chk("mid_after_data", res, 64'h5579C1387B228445);
    chk("mid_after_lat", lat, 32);

    // random traffic against the model, plus DUT round trips
    for (int i = 0; i < 24; i++) begin
      w = bit'($urandom_range(0, 1));
      m = bit'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      if (!w) k[127:80] = '0;
      exp = ref_run(w, m, d, k);
      do_op(w, m, d, k, int'($urandom_range(0, 4)),
            bit'($urandom_range(0, 1)), res, lat);
      chk($sformatf("rnd%0d_w%0d_m%0d_data", i, w, m), res, exp);
      chk($sformatf("rnd%0d_lat", i), lat, m ? 64 : 32);
      if (!m) begin
        do_op(w, 1'b1, res, k, 0, 1'b0, res, lat);
        chk($sformatf("rnd%0d_roundtrip", i), res, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
